// File: rtl/simple_fifo_wr_arbiter.sv
// Frame-aware round-robin arbiter sharing one FIFO-adapter write port between N_REQ producers.
// A granted producer owns the port until its last beat, or until MAX_BEATS forces a release.
module simple_fifo_wr_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MAX_BEATS  = 256,
    parameter int unsigned ID_WIDTH   = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_REQ-1:0]            req_ena,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_dat,
    input  logic [N_REQ-1:0]            req_last,
    output logic [N_REQ-1:0]            req_ready,
    output logic                        fifo_wr_ena,
    output logic [DATA_WIDTH-1:0]       fifo_wr_dat,
    output logic                        fifo_wr_last,
    input  logic                        fifo_wr_full,
    output logic                        grant_vld,
    output logic [ID_WIDTH-1:0]         grant_id,
    output logic                        trunc_err
);

    localparam int unsigned CntWidth = $clog2(MAX_BEATS) + 1;
    localparam logic [CntWidth-1:0] CntLimit = CntWidth'(MAX_BEATS - 1);
    localparam logic [ID_WIDTH-1:0] LastId = ID_WIDTH'(N_REQ - 1);
    localparam logic [ID_WIDTH:0] NumReq = (ID_WIDTH + 1)'(N_REQ);

    typedef enum logic [0:0] {StIdle, StLock} state_e;

    state_e              state_q;
    logic [ID_WIDTH-1:0] rr_ptr_q;
    logic [CntWidth-1:0] beat_cnt_q;

    logic                  in_lock;
    logic                  owner_ena;
    logic                  owner_last;
    logic [DATA_WIDTH-1:0] owner_dat;
    logic                  at_limit;
    logic                  accept;
    logic [2*N_REQ-1:0]    req_rot;
    logic [ID_WIDTH:0]     win_off;
    logic [ID_WIDTH:0]     win_sum;
    logic [ID_WIDTH-1:0]   winner;
    logic [ID_WIDTH-1:0]   next_rr;

    assign in_lock = (state_q == StLock);
    assign at_limit = (beat_cnt_q == CntLimit);
    assign next_rr = (grant_id == LastId) ? '0 : grant_id + 1'b1;

    // Rotate requests so bit 0 is rr_ptr, take the lowest set bit, then map back to an index.
    always_comb begin
        req_rot = {req_ena, req_ena} >> rr_ptr_q;
        win_off = '0;
        for (int k = int'(N_REQ) - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = (ID_WIDTH + 1)'(k);
            end
        end
        win_sum = {1'b0, rr_ptr_q} + win_off;
        if (win_sum >= NumReq) begin
            win_sum = win_sum - NumReq;
        end
        winner = win_sum[ID_WIDTH-1:0];
    end

    always_comb begin
        owner_ena  = 1'b0;
        owner_last = 1'b0;
        owner_dat  = '0;
        req_ready  = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (grant_id == ID_WIDTH'(i)) begin
                owner_ena    = req_ena[i];
                owner_last   = req_last[i];
                owner_dat    = req_dat[i*DATA_WIDTH +: DATA_WIDTH];
                req_ready[i] = in_lock & ~fifo_wr_full;
            end
        end
        accept       = in_lock & owner_ena & ~fifo_wr_full;
        fifo_wr_ena  = accept;
        fifo_wr_dat  = owner_dat;
        fifo_wr_last = in_lock & (owner_last | at_limit);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
            grant_vld  <= 1'b0;
            grant_id   <= '0;
            trunc_err  <= 1'b0;
        end else begin
            trunc_err <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (|req_ena) begin
                        grant_id   <= winner;
                        grant_vld  <= 1'b1;
                        beat_cnt_q <= '0;
                        state_q    <= StLock;
                    end
                end
                StLock: begin
                    if (accept) begin
                        if (fifo_wr_last) begin
                            state_q    <= StIdle;
                            grant_vld  <= 1'b0;
                            rr_ptr_q   <= next_rr;
                            beat_cnt_q <= '0;
                            trunc_err  <= at_limit & ~owner_last;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_simple_fifo_wr_arbiter.sv
// Bench for simple_fifo_wr_arbiter: hand-derived vector table, directed sequences and a
// randomized push-style run checked against a cycle model and a per-requester sequence scoreboard.
module tb_simple_fifo_wr_arbiter;

    localparam int N   = 4;
    localparam int DW  = 16;
    localparam int MB  = 4;
    localparam int IDW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_ena;
    logic [N*DW-1:0] req_dat;
    logic [N-1:0]    req_last;
    logic [N-1:0]    req_ready;
    logic            fifo_wr_ena;
    logic [DW-1:0]   fifo_wr_dat;
    logic            fifo_wr_last;
    logic            fifo_wr_full;
    logic            grant_vld;
    logic [IDW-1:0]  grant_id;
    logic            trunc_err;

    always #5 clk = ~clk;

    simple_fifo_wr_arbiter #(
        .N_REQ      (N),
        .DATA_WIDTH (DW),
        .MAX_BEATS  (MB),
        .ID_WIDTH   (IDW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_ena      (req_ena),
        .req_dat      (req_dat),
        .req_last     (req_last),
        .req_ready    (req_ready),
        .fifo_wr_ena  (fifo_wr_ena),
        .fifo_wr_dat  (fifo_wr_dat),
        .fifo_wr_last (fifo_wr_last),
        .fifo_wr_full (fifo_wr_full),
        .grant_vld    (grant_vld),
        .grant_id     (grant_id),
        .trunc_err    (trunc_err)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    typedef struct {
        bit        rst;
        bit [3:0]  ena;
        bit [3:0]  last;
        bit        full;
        bit [15:0] d;
        bit        vld;
        bit [1:0]  gid;
        bit [3:0]  rdy;
        bit        wena;
        bit [15:0] wdat;
        bit        wlast;
        bit        trunc;
    } vec_t;

    function automatic vec_t mk(bit r, bit [3:0] e, bit [3:0] l, bit f, bit [15:0] d, bit vl,
                                bit [1:0] gi, bit [3:0] rd, bit we, bit [15:0] wd, bit wl,
                                bit tr);
        vec_t v;
        v.rst = r; v.ena = e; v.last = l; v.full = f; v.d = d;
        v.vld = vl; v.gid = gi; v.rdy = rd; v.wena = we; v.wdat = wd; v.wlast = wl; v.trunc = tr;
        return v;
    endfunction

    // Behavioural model: owner index (-1 when idle), beats taken, round-robin start, pulse.
    int m_own, m_gid, m_cnt, m_rr;
    bit m_trunc;
    // Push-style producers: beats left in the current frame and next sequence number.
    int rem[N];
    int seq[N];
    int rx_seq[16];
    int refill;
    int got[$];
    bit prev_vld;

    task automatic model_reset();
        m_own = -1; m_gid = 0; m_cnt = 0; m_rr = 0; m_trunc = 1'b0;
    endtask

    task automatic clear_stim();
        for (int i = 0; i < N; i++) begin
            rem[i] = 0;
            seq[i] = 0;
        end
        for (int i = 0; i < 16; i++) rx_seq[i] = 0;
        got.delete();
        prev_vld = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; req_ena = '0; req_last = '0; fifo_wr_full = 1'b0; req_dat = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        prev_vld = 1'b0;
    endtask

    task automatic cycle(input bit r, input bit f, input bit gate);
        bit [N-1:0]  e;
        bit [N-1:0]  l;
        bit [N-1:0]  xr;
        bit          acc;
        bit          xl;
        int          g;
        int          w;
        logic [3:0]  id;
        for (int i = 0; i < N; i++) begin
            e[i] = (rem[i] > 0) && (!gate || $urandom_range(0, 3) != 0);
            l[i] = (rem[i] == 1);
            req_dat[i*DW +: DW] = {4'(i), 12'(seq[i])};
        end
        rst = r; fifo_wr_full = f; req_ena = e; req_last = l;
        @(negedge clk);
        g = m_own;
        chk("grant_vld", grant_vld, 32'(g >= 0));
        if (g >= 0) chk("grant_id", grant_id, m_gid);
        chk("trunc_err", trunc_err, m_trunc);
        acc = 1'b0; xr = '0; xl = 1'b0;
        if (g >= 0) begin
            acc = e[g] && !f;
            if (!f) xr[g] = 1'b1;
            xl = l[g] || (m_cnt == MB - 1);
        end
        chk("req_ready", req_ready, xr);
        chk("fifo_wr_ena", fifo_wr_ena, acc);
        if (acc) begin
            chk("fifo_wr_last", fifo_wr_last, xl);
            chk("fifo_wr_dat", fifo_wr_dat, {4'(g), 12'(seq[g])});
        end
        // Per-requester stream must arrive gap-free and in order.
        if (fifo_wr_ena === 1'b1) begin
            id = fifo_wr_dat[15:12];
            chk("wr_seq", fifo_wr_dat[11:0], 12'(rx_seq[id]));
            rx_seq[id]++;
        end
        if (grant_vld === 1'b1 && !prev_vld) got.push_back(int'(grant_id));
        prev_vld = (grant_vld === 1'b1);
        if (acc) begin
            seq[g]++;
            rem[g]--;
        end
        if (r) begin
            model_reset();
        end else begin
            m_trunc = 1'b0;
            if (g < 0) begin
                for (int k = 0; k < N; k++) begin
                    w = (m_rr + k) % N;
                    if (e[w]) begin
                        m_own = w; m_gid = w; m_cnt = 0;
                        break;
                    end
                end
            end else if (acc) begin
                if (xl) begin
                    m_trunc = !l[g];
                    m_own = -1;
                    m_rr = (g + 1) % N;
                    m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rem[i] == 0) begin
                if (refill == 2) rem[i] = 2;
                else if (refill == 1 && $urandom_range(0, 3) == 0) rem[i] = $urandom_range(1, 6);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t tbl[$];
        refill = 0;
        clear_stim();
        do_reset();

        //           rst ena   last  f  d      vld gid rdy   we wdat     wl tr
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 16'h00, 0, 0, 4'h0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'h1, 4'h0, 0, 16'h00, 0, 0, 4'h0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'h1, 4'h0, 0, 16'h00, 1, 0, 4'h1, 1, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'h1, 4'h0, 0, 16'h01, 1, 0, 4'h1, 1, 16'h0001, 0, 0));
        tbl.push_back(mk(0, 4'h1, 4'h0, 0, 16'h02, 1, 0, 4'h1, 1, 16'h0002, 0, 0));
        tbl.push_back(mk(0, 4'h1, 4'h1, 0, 16'h03, 1, 0, 4'h1, 1, 16'h0003, 1, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 16'h00, 0, 0, 4'h0, 0, 16'h0000, 0, 0));
        // req2 sends 6 beats with last only on the sixth: forced release after four.
        tbl.push_back(mk(0, 4'h4, 4'h0, 0, 16'h10, 0, 0, 4'h0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'h4, 4'h0, 0, 16'h10, 1, 2, 4'h4, 1, 16'h2010, 0, 0));
        tbl.push_back(mk(0, 4'h4, 4'h0, 0, 16'h11, 1, 2, 4'h4, 1, 16'h2011, 0, 0));
        tbl.push_back(mk(0, 4'h4, 4'h0, 0, 16'h12, 1, 2, 4'h4, 1, 16'h2012, 0, 0));
        tbl.push_back(mk(0, 4'h4, 4'h0, 0, 16'h13, 1, 2, 4'h4, 1, 16'h2013, 1, 0));
        tbl.push_back(mk(0, 4'h4, 4'h0, 0, 16'h14, 0, 0, 4'h0, 0, 16'h0000, 0, 1));
        tbl.push_back(mk(0, 4'h4, 4'h0, 0, 16'h14, 1, 2, 4'h4, 1, 16'h2014, 0, 0));
        tbl.push_back(mk(0, 4'h4, 4'h4, 0, 16'h15, 1, 2, 4'h4, 1, 16'h2015, 1, 0));
        // req1 stalled by full, then resumes on the cycle full drops.
        tbl.push_back(mk(0, 4'h2, 4'h0, 0, 16'h20, 0, 0, 4'h0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'h2, 4'h0, 1, 16'h20, 1, 1, 4'h0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'h2, 4'h0, 1, 16'h20, 1, 1, 4'h0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'h2, 4'h0, 0, 16'h20, 1, 1, 4'h2, 1, 16'h1020, 0, 0));
        tbl.push_back(mk(0, 4'h2, 4'h2, 0, 16'h21, 1, 1, 4'h2, 1, 16'h1021, 1, 0));
        // All request single-beat frames: rotation 2,3 then wrap to 0.
        tbl.push_back(mk(0, 4'hF, 4'hF, 0, 16'h30, 0, 0, 4'h0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 0, 16'h30, 1, 2, 4'h4, 1, 16'h2030, 1, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 0, 16'h30, 0, 0, 4'h0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 0, 16'h30, 1, 3, 4'h8, 1, 16'h3030, 1, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 0, 16'h30, 0, 0, 4'h0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'hF, 4'hF, 0, 16'h30, 1, 0, 4'h1, 1, 16'h0030, 1, 0));
        // Reset during req3's second beat, then lowest active index wins.
        tbl.push_back(mk(0, 4'h8, 4'h0, 0, 16'h40, 0, 0, 4'h0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'h8, 4'h0, 0, 16'h40, 1, 3, 4'h8, 1, 16'h3040, 0, 0));
        tbl.push_back(mk(1, 4'h8, 4'h0, 0, 16'h41, 1, 3, 4'h8, 1, 16'h3041, 0, 0));
        tbl.push_back(mk(0, 4'hA, 4'h0, 0, 16'h42, 0, 0, 4'h0, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'hA, 4'h0, 0, 16'h42, 1, 1, 4'h2, 1, 16'h1042, 0, 0));
        // Bubble mid-frame keeps the grant.
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 16'h43, 1, 1, 4'h2, 0, 16'h0000, 0, 0));
        tbl.push_back(mk(0, 4'h2, 4'h2, 0, 16'h43, 1, 1, 4'h2, 1, 16'h1043, 1, 0));
        tbl.push_back(mk(0, 4'h0, 4'h0, 0, 16'h00, 0, 0, 4'h0, 0, 16'h0000, 0, 0));

        for (int n = 0; n < tbl.size(); n++) begin
            rst = tbl[n].rst; req_ena = tbl[n].ena; req_last = tbl[n].last;
            fifo_wr_full = tbl[n].full;
            for (int i = 0; i < N; i++) req_dat[i*DW +: DW] = tbl[n].d + 16'(i * 16'h1000);
            @(negedge clk);
            chk($sformatf("v%0d_grant_vld", n), grant_vld, tbl[n].vld);
            if (tbl[n].vld) chk($sformatf("v%0d_grant_id", n), grant_id, tbl[n].gid);
            chk($sformatf("v%0d_req_ready", n), req_ready, tbl[n].rdy);
            chk($sformatf("v%0d_wr_ena", n), fifo_wr_ena, tbl[n].wena);
            chk($sformatf("v%0d_trunc", n), trunc_err, tbl[n].trunc);
            if (tbl[n].wena) begin
                chk($sformatf("v%0d_wr_dat", n), fifo_wr_dat, tbl[n].wdat);
                chk($sformatf("v%0d_wr_last", n), fifo_wr_last, tbl[n].wlast);
            end
            @(posedge clk);
            #1;
        end

        // All four stream back-to-back 2-beat frames: grants rotate 0,1,2,3,...
        clear_stim();
        do_reset();
        refill = 2;
        for (int i = 0; i < N; i++) rem[i] = 2;
        repeat (30) cycle(1'b0, 1'b0, 1'b0);
        chk("rr_grants_seen", 32'(got.size() >= 8), 1);
        for (int k = 0; k < 8 && k < got.size(); k++) chk("rr_order", got[k], k % 4);

        // req0 and req2 queue behind req3: order after release is 0 then 2.
        refill = 0;
        clear_stim();
        do_reset();
        rem[3] = 3;
        cycle(1'b0, 1'b0, 1'b0);
        rem[0] = 1;
        rem[2] = 1;
        repeat (14) cycle(1'b0, 1'b0, 1'b0);
        chk("wrap_grants_seen", got.size(), 3);
        if (got.size() == 3) begin
            chk("wrap_first", got[0], 3);
            chk("wrap_second", got[1], 0);
            chk("wrap_third", got[2], 2);
        end

        // req1 8-beat frame with full held for three cycles mid-frame.
        clear_stim();
        do_reset();
        rem[1] = 8;
        for (int c = 0; c < 20; c++) cycle(1'b0, (c >= 4 && c <= 6), 1'b0);
        chk("stall_beats_out", rx_seq[1], 8);
        chk("stall_beats_left", rem[1], 0);

        // Randomized traffic, backpressure, bubbles and occasional reset.
        clear_stim();
        do_reset();
        refill = 1;
        repeat (3000) cycle($urandom_range(0, 199) == 0, $urandom_range(0, 2) == 0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
